// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared constants and configuration check for the pipelined adder
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    // Legal only when the operand splits into equal non-empty slices.
    function automatic bit stages_divide_width(input int n, input int stages);
        return (stages > 0) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// rtl/pipelined_adder_slice.sv - W-bit combinational a+b+ci slice
// Ports:
//   a, b   : W-bit slice operands (b already inverted for subtraction)
//   ci     : carry into bit 0 of the slice
//   sum    : W-bit slice result
//   co     : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (signed overflow = c_msb ^ co in the top slice)
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign sum   = full[W-1:0];
    assign co    = full[W];
    // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out of it.
    assign c_msb = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - skewed-pipeline N-bit add/subtract with valid/ready handshake
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = pipeline advance enable)
//   a, b, cin, sub       : operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready: result handshake
//   y, cout, ovf         : result mod 2^N, carry out of bit N-1, signed overflow
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int N      = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;

    if (!stages_divide_width(N, STAGES)) begin : g_bad_cfg
        $fatal(1, "pipelined_adder: N must be a positive multiple of STAGES");
    end

    // *_s: inputs seen by stage k this cycle; *_q: registers owned by stage k.
    logic [N-1:0] a_s [STAGES];
    logic [N-1:0] b_s [STAGES];
    logic [N-1:0] r_s [STAGES];
    logic         c_s [STAGES];
    logic         v_s [STAGES];
    logic         cm_s [STAGES];

    logic [N-1:0] a_q [STAGES];
    logic [N-1:0] b_q [STAGES];
    logic [N-1:0] r_q [STAGES];
    logic         c_q [STAGES];
    logic         v_q [STAGES];
    logic         ovf_q;

    logic en;

    // The whole pipeline moves together; it only freezes when a result is
    // waiting and downstream refuses it. Bubbles are not squeezed out.
    assign en       = !v_q[STAGES-1] || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            assign a_s[k] = a;
            assign b_s[k] = sub ? ~b : b;
            assign c_s[k] = sub | cin;
            assign r_s[k] = '0;
            assign v_s[k] = in_valid;
        end else begin : g_next
            assign a_s[k] = a_q[k-1];
            assign b_s[k] = b_q[k-1];
            assign c_s[k] = c_q[k-1];
            assign r_s[k] = r_q[k-1];
            assign v_s[k] = v_q[k-1];
        end

        logic [W-1:0] sum;
        logic         co;
        logic [N-1:0] r_next;
        logic [N-1:0] a_r;
        logic [N-1:0] b_r;
        logic [N-1:0] r_r;
        logic         c_r;
        logic         v_r;

        adder_slice #(.W(W)) u_slice (
            .a     (a_s[k][k*W +: W]),
            .b     (b_s[k][k*W +: W]),
            .ci    (c_s[k]),
            .sum   (sum),
            .co    (co),
            .c_msb (cm_s[k])
        );

        // Lower slices were resolved by earlier stages; splice this slice in.
        always_comb begin
            r_next = r_s[k];
            r_next[k*W +: W] = sum;
        end

        // Operands travel whole down the pipe; each stage only reads its own
        // slice, so bits already consumed are simply ignored downstream.
        always_ff @(posedge clk) begin
            if (rst) begin
                a_r <= '0;
                b_r <= '0;
                r_r <= '0;
                c_r <= 1'b0;
                v_r <= 1'b0;
            end else if (en) begin
                a_r <= a_s[k];
                b_r <= b_s[k];
                r_r <= r_next;
                c_r <= co;
                v_r <= v_s[k];
            end
        end

        assign a_q[k] = a_r;
        assign b_q[k] = b_r;
        assign r_q[k] = r_r;
        assign c_q[k] = c_r;
        assign v_q[k] = v_r;

        if (k == STAGES - 1) begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= cm_s[k] ^ co;
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign y         = r_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder
module tb_pipelined_adder;

    localparam int N      = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [31:0] y;
        logic        cout;
        logic        ovf;
        int          t_acc;
        int          stalls_acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, y;

    logic        iv1, ir1, cin1, sub1, ov1, or1, co1, of1;
    logic [31:0] a1, b1, y1;
    logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, y32;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    int          stalls = 0;
    bit          prev_stall = 0;
    logic [33:0] prev_out;
    bit          rand_done;

    always #5 clk = ~clk;

    pipelined_adder #(.N(N), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.N(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(ov1),
        .out_ready(or1), .y(y1), .cout(co1), .ovf(of1)
    );

    pipelined_adder #(.N(32), .STAGES(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(ov32),
        .out_ready(or32), .y(y32), .cout(co32), .ovf(of32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the full operands.
    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_,
                                   input logic tc, input logic ts);
        exp_t              e;
        longint unsigned   ua, ub, us;
        longint            sa, sbv, r;
        ua  = {32'd0, ta};
        ub  = {32'd0, tb_};
        sa  = longint'($signed(ta));
        sbv = longint'($signed(tb_));
        if (!ts) begin
            us     = ua + ub + {63'd0, tc};
            e.y    = us[31:0];
            e.cout = (us >= 64'h1_0000_0000);
            r      = sa + sbv + longint'(tc);
        end else begin
            e.y    = ta - tb_;
            e.cout = (ua >= ub);
            r      = sa - sbv;
        end
        e.ovf        = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.t_acc      = 0;
        e.stalls_acc = 0;
        return e;
    endfunction

    // Monitor: samples mid-cycle, so values equal what the next rising edge sees.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (rst) begin
            sb.delete();
            prev_stall = 0;
        end else begin
            check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("hold_out_valid", out_valid, 1);
                check("hold_y_cout_ovf", {y, cout, ovf}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", y);
                end else begin
                    e = sb.pop_front();
                    check("y", y, e.y);
                    check("cout", cout, e.cout);
                    check("ovf", ovf, e.ovf);
                    check("latency", cycle - e.t_acc, STAGES + stalls - e.stalls_acc);
                end
            end
            if (in_valid && in_ready) begin
                e            = model(a, b, cin, sub);
                e.t_acc      = cycle;
                e.stalls_acc = stalls;
                sb.push_back(e);
            end
            if (out_valid && !out_ready) begin
                stalls++;
                prev_stall = 1;
                prev_out   = {y, cout, ovf};
            end else begin
                prev_stall = 0;
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tc, input logic ts);
        bit ok = 0;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb.size() > 0; i++) @(negedge clk);
        check("drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat1, lat32;
        rst = 1'b1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1'b1;
        iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1'b1;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_y", y, 0);
        @(posedge clk);
        #1;

        // Boundary vectors, back to back.
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        send(32'h0, 32'h0, 1'b0, 1'b1);
        drain();

        // Eight random operands, continuous stream.
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        drain();

        // Six operands with a three-cycle back-pressure window mid-stream.
        fork
            for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles_seen", stalls >= 3, 1);

        // Reset with three operations in flight: they must never emerge.
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
        send(32'h5555_5555, 32'h0000_0001, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_y", y, 0);
        check("post_rst_cout_ovf", {cout, ovf}, 0);
        @(posedge clk);
        #1;
        repeat (6) @(posedge clk);
        #1;
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        drain();

        // Long random run with random back-pressure.
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
                rand_done = 1;
            end
            while (!rand_done) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        drain();

        // Degenerate depths: single stage and one bit per stage.
        fork
            begin
                a1 = 32'hFFFF_FFFF; b1 = 32'h1; iv1 = 1'b1;
                @(negedge clk);
                check("s1_in_ready", ir1, 1);
                @(posedge clk);
                #1 iv1 = 1'b0;
                lat1 = 0;
                for (int i = 1; i <= 100 && lat1 == 0; i++) begin
                    @(negedge clk);
                    if (ov1) lat1 = i;
                end
                check("s1_latency", lat1, 1);
                check("s1_y", y1, 0);
                check("s1_cout", co1, 1);
            end
            begin
                a32 = 32'hFFFF_FFFF; b32 = 32'h1; iv32 = 1'b1;
                @(negedge clk);
                check("s32_in_ready", ir32, 1);
                @(posedge clk);
                #1 iv32 = 1'b0;
                lat32 = 0;
                for (int i = 1; i <= 100 && lat32 == 0; i++) begin
                    @(negedge clk);
                    if (ov32) lat32 = i;
                end
                check("s32_latency", lat32, 32);
                check("s32_y", y32, 0);
                check("s32_cout", co32, 1);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
